// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt detector: mode encoding and
// the per-channel event decode used by the top level.
package gpio_irq_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF    = 3'b000;
    localparam mode_t MODE_RISE   = 3'b001;
    localparam mode_t MODE_FALL   = 3'b010;
    localparam mode_t MODE_BOTH   = 3'b011;
    localparam mode_t MODE_LVL_HI = 3'b100;
    localparam mode_t MODE_LVL_LO = 3'b101;

    // Edge modes look at the value about to be loaded into filtered (the
    // input bit on an update); level modes look at the registered value.
    function automatic logic event_set(
        input mode_t m,
        input logic  update,
        input logic  new_val,
        input logic  level
    );
        logic s;
        s = 1'b0;
        case (m)
            MODE_RISE:   s = update & new_val;
            MODE_FALL:   s = update & ~new_val;
            MODE_BOTH:   s = update;
            MODE_LVL_HI: s = level;
            MODE_LVL_LO: s = ~level;
            default:     s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gpio_glitch_filter.sv
// Single-channel glitch filter: the input must differ from the filtered
// state for filter_len+1 consecutive samples before filtered follows it.
module gpio_glitch_filter #(
    parameter int FILTER_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   warm,
    input  logic                   in,
    input  logic [FILTER_BITS-1:0] filter_len,
    output logic                   filtered,
    output logic                   update
);

    logic [FILTER_BITS-1:0] count;

    // >= rather than == so a shortened filter_len mid-count still resolves.
    assign update = !warm && (in != filtered) && (count >= filter_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            filtered <= 1'b0;
        end else if (warm) begin
            count    <= '0;
            filtered <= in;
        end else if (in == filtered) begin
            count    <= '0;
        end else if (update) begin
            count    <= '0;
            filtered <= in;
        end else begin
            count    <= count + FILTER_BITS'(1);
        end
    end

endmodule

// File: rtl/gpio_irq_detector.sv
// Per-channel GPIO interrupt detector: warm-up gate, glitch filters, mode
// decode, sticky write-1-to-clear pending flags and a masked irq line.
module gpio_irq_detector
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FILTER_BITS = 4,
    parameter int WARMUP      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in,
    input  logic [MODE_W*WIDTH-1:0] mode,
    input  logic [FILTER_BITS-1:0]  filter_len,
    input  logic [WIDTH-1:0]        mask,
    input  logic [WIDTH-1:0]        clear,
    output logic [WIDTH-1:0]        filtered,
    output logic [WIDTH-1:0]        pending,
    output logic                    irq
);

    localparam logic [7:0] WARMUP_C = 8'(WARMUP);

    logic [7:0]       warm_cnt;
    logic             warm;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] set;

    assign warm = (warm_cnt < WARMUP_C);

    // Saturates at WARMUP; only reset restarts the warm-up window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (warm) begin
            warm_cnt <= warm_cnt + 8'd1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gpio_glitch_filter #(
            .FILTER_BITS(FILTER_BITS)
        ) u_filter (
            .clk        (clk),
            .reset      (reset),
            .warm       (warm),
            .in         (in[i]),
            .filter_len (filter_len),
            .filtered   (filtered[i]),
            .update     (update[i])
        );

        assign set[i] = !warm &&
                        event_set(mode_t'(mode[MODE_W*i +: MODE_W]),
                                  update[i], in[i], filtered[i]);
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear) | set;
        end
    end

    assign irq = |(pending & mask);

endmodule

// File: tb/tb_gpio_irq_detector.sv
// Directed bench for gpio_irq_detector: expected filtered/pending/irq are
// queued with each stimulus step and compared one cycle later.
module tb_gpio_irq_detector;

    logic        clk;
    logic        reset;
    logic [15:0] in_sig;
    logic [47:0] mode;
    logic [3:0]  filter_len;
    logic [15:0] mask;
    logic [15:0] clear;
    logic [15:0] filtered;
    logic [15:0] pending;
    logic        irq;

    logic [32:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          errors;

    gpio_irq_detector #(
        .WIDTH(16),
        .FILTER_BITS(4),
        .WARMUP(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_sig),
        .mode       (mode),
        .filter_len (filter_len),
        .mask       (mask),
        .clear      (clear),
        .filtered   (filtered),
        .pending    (pending),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mode_all(input logic [2:0] m);
        logic [47:0] r;
        for (int i = 0; i < 16; i++) r[3*i +: 3] = m;
        return r;
    endfunction

    task automatic check_out();
        logic [32:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert ({filtered, pending, irq} === e) else begin
            errors++;
            $error("FAIL %s: got filtered=%h pending=%h irq=%b, expected filtered=%h pending=%h irq=%b",
                   t, filtered, pending, irq, e[32:17], e[16:1], e[0]);
        end
    endtask

    task automatic expect_now(input string t, input logic [15:0] f,
                              input logic [15:0] p, input logic i);
        exp_q.push_back({f, p, i});
        tag_q.push_back(t);
        check_out();
    endtask

    // Drive one cycle of stimulus, queue its expected result, check after the edge.
    task automatic step(input string t, input logic [15:0] in_v, input logic [15:0] clr_v,
                        input logic [15:0] f, input logic [15:0] p, input logic i);
        in_sig = in_v;
        clear  = clr_v;
        exp_q.push_back({f, p, i});
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        clear = '0;
        check_out();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        in_sig     = 16'hFFFF;
        mode       = mode_all(3'b001);
        filter_len = 4'd0;
        mask       = 16'hFFFF;
        clear      = '0;

        // Reset and warm-up
        @(posedge clk);
        #1;
        expect_now("reset_state", 16'h0000, 16'h0000, 1'b0);
        reset = 1'b0;
        step("warm_e1", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("warm_e2", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("warm_e3", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("warm_e4", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("post_warm_e5", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);

        // Rising / falling / both with N=0
        mode = mode_all(3'b000);
        step("edge_prep_low", 16'hFFF8, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        mode[2:0] = 3'b001;
        mode[5:3] = 3'b010;
        mode[8:6] = 3'b011;
        step("edge_rise", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0005, 1'b1);
        step("edge_fall", 16'hFFF8, 16'h0, 16'hFFF8, 16'h0007, 1'b1);
        step("edge_clear", 16'hFFF8, 16'h0007, 16'hFFF8, 16'h0000, 1'b0);

        // Glitch filter N=3
        mode       = mode_all(3'b000);
        mode[2:0]  = 3'b001;
        filter_len = 4'd3;
        step("glitch3_a", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("glitch3_b", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("glitch3_c", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("glitch3_end", 16'hFFF8, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("pulse4_a", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("pulse4_b", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("pulse4_c", 16'hFFF9, 16'h0, 16'hFFF8, 16'h0, 1'b0);
        step("pulse4_d", 16'hFFF9, 16'h0, 16'hFFF9, 16'h0001, 1'b1);
        step("pulse4_clear", 16'hFFF9, 16'h0001, 16'hFFF9, 16'h0000, 1'b0);

        // Level-low on ch5, N=3
        mode      = mode_all(3'b000);
        mode[17:15] = 3'b101;
        step("lvl_fall_a", 16'hFFD9, 16'h0, 16'hFFF9, 16'h0, 1'b0);
        step("lvl_fall_b", 16'hFFD9, 16'h0, 16'hFFF9, 16'h0, 1'b0);
        step("lvl_fall_c", 16'hFFD9, 16'h0, 16'hFFF9, 16'h0, 1'b0);
        step("lvl_fall_d", 16'hFFD9, 16'h0, 16'hFFD9, 16'h0, 1'b0);
        step("lvl_set", 16'hFFD9, 16'h0, 16'hFFD9, 16'h0020, 1'b1);
        step("lvl_clear_held", 16'hFFD9, 16'h0020, 16'hFFD9, 16'h0020, 1'b1);
        step("lvl_rise_a", 16'hFFF9, 16'h0, 16'hFFD9, 16'h0020, 1'b1);
        step("lvl_rise_b", 16'hFFF9, 16'h0, 16'hFFD9, 16'h0020, 1'b1);
        step("lvl_rise_c", 16'hFFF9, 16'h0, 16'hFFD9, 16'h0020, 1'b1);
        step("lvl_rise_d", 16'hFFF9, 16'h0, 16'hFFF9, 16'h0020, 1'b1);
        step("lvl_clear_gone", 16'hFFF9, 16'h0020, 16'hFFF9, 16'h0000, 1'b0);

        // Set beats clear on ch3, then masking
        mode       = mode_all(3'b000);
        mode[11:9] = 3'b001;
        filter_len = 4'd0;
        step("sc_prep_low", 16'hFFF1, 16'h0, 16'hFFF1, 16'h0, 1'b0);
        step("sc_set_wins", 16'hFFF9, 16'h0008, 16'hFFF9, 16'h0008, 1'b1);
        mask = 16'hFFF7;
        step("mask_off", 16'hFFF9, 16'h0, 16'hFFF9, 16'h0008, 1'b0);

        // Reset mid-filter, N=7 with ch0 counter at 5
        mask       = 16'hFFFF;
        mode       = mode_all(3'b001);
        filter_len = 4'd7;
        for (int k = 0; k < 5; k++)
            step("n7_count", 16'hFFF8, 16'h0, 16'hFFF9, 16'h0008, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        expect_now("async_reset", 16'h0000, 16'h0000, 1'b0);
        step("reset_held", 16'h00FF, 16'h0, 16'h0000, 16'h0000, 1'b0);
        reset      = 1'b0;
        filter_len = 4'd0;
        step("rewarm_e1", 16'h00FF, 16'h0, 16'h00FF, 16'h0, 1'b0);
        step("rewarm_e2", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("rewarm_e3", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        step("rewarm_e4", 16'hFFFE, 16'h0, 16'hFFFE, 16'h0, 1'b0);
        step("first_event_e5", 16'hFFFF, 16'h0, 16'hFFFF, 16'h0001, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq_detector.md
# gpio_irq_detector

Parametrised per-channel GPIO interrupt detector that generalises the fixed rising/falling edge detector. It adds per-channel mode selection (edge or level), a programmable glitch filter, a configurable post-reset warm-up, sticky pending flags with write-1-to-clear, and a masked aggregate interrupt line. It sits between the GPIO input synchroniser and the interrupt controller; register-file glue drives `mode`, `mask`, `filter_len` and `clear`.

## Interface

- Clocking: one clock; reset is asynchronous and active-high.
- `WIDTH`, default 16: number of GPIO channels.
- `FILTER_BITS`, default 4: width of the glitch-filter length and per-channel counter.
- `WARMUP`, default 4: cycles after reset during which no events are raised (covers synchroniser latency). Legal range 1..255.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in`  in  WIDTH: synchronised GPIO input levels.
- `mode`  in  3*WIDTH: per-channel mode. Channel i uses `mode[3i+2:3i]`.
- `filter_len`  in  FILTER_BITS: global filter length N; 0 bypasses filtering.
- `mask`  in  WIDTH: per-channel interrupt enable for `irq`.
- `clear`  in  WIDTH: write-1-to-clear strobe for `pending`, one cycle per write.
- `filtered`  out  WIDTH: debounced input state, registered.
- `pending`  out  WIDTH: sticky per-channel event flags, registered.
- `irq`  out  1: `|(pending & mask)`, combinational from registers.

## Operation

- Mode encoding:
  - 3'b000: disabled.
  - 3'b001: rising edge.
  - 3'b010: falling edge.
  - 3'b011: both edges.
  - 3'b100: level high.
  - 3'b101: level low.
  - 3'b110 and 3'b111: disabled.
- Reset values: `filtered`=0, `pending`=0, `irq`=0, filter counters 0, warm-up counter 0.
- Warm-up, while the warm-up counter is below WARMUP:
  - `filtered` loads `in` directly every cycle and counters are held at 0.
  - `set` is forced to 0.
  - `clear` still acts on `pending`.
  - The warm-up counter saturates at WARMUP and never wraps.
- Filter, per channel, after warm-up:
  - If `in[i]==filtered[i]`: counter goes to 0.
  - Else, if counter==N: `filtered[i]` takes `in[i]` and counter goes to 0. This is the update event.
  - Else: counter increments.
  - An input must therefore differ for N+1 consecutive samples before `filtered` changes.
  - A glitch shorter than N+1 samples resets the count and does not update.
  - Counter width is FILTER_BITS. The counter never exceeds N, so it never overflows.
- Event set term, per channel:
  - Rising: update and new value 1.
  - Falling: update and new value 0.
  - Both: any update.
  - Level high: `filtered[i]==1` (current registered value).
  - Level low: `filtered[i]==0`.
  - Disabled: 0.
- Pending update: `pending[i] <= (pending[i] & ~clear[i]) | set[i]`.
  - Set wins over a simultaneous clear.
  - A level-mode channel therefore re-asserts `pending` while its level persists.
- `mode` and `mask` changes take effect on the next edge. Disabling a channel does not clear its `pending`. `mask` affects only `irq`, never `pending`.
- `filter_len` change mid-count: the new N is compared against the current counter. If the counter already exceeds the new N, the next differing sample updates, because the comparison is counter>=N.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and warm-up restarts on deassertion.

## Timing

- Edge mode: an input change first sampled at edge k updates `filtered` and sets `pending` at edge k+N. `irq` rises in the same cycle (combinational).
- Level mode: `pending` sets one edge after `filtered` reaches the active level.
- `clear` at edge k: `pending` low after edge k unless set in that same cycle.
- First possible event: updates occurring at edge WARMUP+1 after reset deassertion.

## Structure

- Package `gpio_irq_pkg`:
  - Mode encoding localparams: `MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`, `MODE_LVL_HI`, `MODE_LVL_LO`.
  - Mode field width constant (3).
- Sub-module `gpio_glitch_filter`:
  - One channel: counter plus filtered bit.
  - Ports: `clk`, `reset`, `warm`, `in`, `filter_len`, `filtered`, `update`.
  - Instantiated WIDTH times in a generate loop.
- Top level holds the warm-up counter, mode decode, pending register and `irq` reduction.

## Test plan

- Reset and warm-up, WARMUP=4, `in`=16'hFFFF during reset, all rising:
  - `filtered`=16'hFFFF after edge 1.
  - `pending`=0 throughout warm-up; no false events.
- Rising and falling, N=0, ch0 rising, ch1 falling, ch2 both, `mask`=all ones:
  - Toggle `in[2:0]` 0→1→0.
  - Required: `pending` = 3'b101 after the rise, then 3'b111 after the fall.
  - `irq`=1 on the same cycles as those `pending` updates.
- Glitch filter, N=3:
  - A 3-cycle pulse on ch0 leaves `filtered` and `pending` at 0.
  - A 4-cycle pulse sets `pending[0]` at the 4th edge.
- Level mode, ch5 level-low, `in[5]`=0 held:
  - `pending[5]` stays 1 through a `clear[5]` pulse.
  - After `in[5]`→1 and the filter delay, a `clear[5]` pulse takes `pending[5]` to 0.
- Simultaneous set and clear: rising event on ch3 in the same cycle as `clear[3]` → `pending[3]`=1.
  - Masking: `mask[3]`=0 → `irq`=0 while `pending[3]`=1.
- Reset mid-filter, N=7, counter at 5:
  - Assert `reset` → `filtered`, `pending` and `irq` go to 0 asynchronously.
  - Warm-up repeats before any new event.
